// File: rtl/pixel_window_input_if.sv
// Handshake bundle for pixel_window_input: the 8-bit pixel input stream and
// the 4-tap signed window output stream.
interface pixel_window_input_if #(
    parameter int OUTPUT_WIDTH = 9
);
    logic [7:0]                     s_pixel;
    logic                           s_valid;
    logic                           s_last;
    logic                           s_ready;
    logic signed [OUTPUT_WIDTH-1:0] m_tap0;
    logic signed [OUTPUT_WIDTH-1:0] m_tap1;
    logic signed [OUTPUT_WIDTH-1:0] m_tap2;
    logic signed [OUTPUT_WIDTH-1:0] m_tap3;
    logic                           m_valid;
    logic                           m_last;
    logic                           m_ready;

    // Block side: consumes pixels, produces windows.
    modport slave (
        input  s_pixel, s_valid, s_last, m_ready,
        output s_ready, m_tap0, m_tap1, m_tap2, m_tap3, m_valid, m_last
    );

    // Environment side: produces pixels, consumes windows.
    modport master (
        output s_pixel, s_valid, s_last, m_ready,
        input  s_ready, m_tap0, m_tap1, m_tap2, m_tap3, m_valid, m_last
    );
endinterface

// File: rtl/pixel_window_input.sv
// Widens 8-bit pixels to signed taps and emits one edge-replicated 4-tap
// horizontal window per input pixel for the bicubic horizontal filter.
module pixel_window_input #(
    parameter int OUTPUT_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  aresetn,
    pixel_window_input_if.slave   bus
);
    typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [1:0] count_q, count_d;
    logic [1:0] drain_q, drain_d;
    logic [7:0] sh0_q, sh0_d;
    logic [7:0] sh1_q, sh1_d;
    logic [7:0] sh2_q, sh2_d;
    logic signed [OUTPUT_WIDTH-1:0] tap0_q, tap0_d;
    logic signed [OUTPUT_WIDTH-1:0] tap1_q, tap1_d;
    logic signed [OUTPUT_WIDTH-1:0] tap2_q, tap2_d;
    logic signed [OUTPUT_WIDTH-1:0] tap3_q, tap3_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic       out_free;
    logic       accept;

    function automatic logic signed [OUTPUT_WIDTH-1:0] widen(input logic [7:0] p);
        return $signed({{(OUTPUT_WIDTH-8){1'b0}}, p});
    endfunction

    assign out_free      = !m_valid_q || bus.m_ready;
    assign bus.s_ready   = (state_q != DRAIN) && out_free;
    assign accept        = bus.s_valid && bus.s_ready;

    assign bus.m_tap0    = tap0_q;
    assign bus.m_tap1    = tap1_q;
    assign bus.m_tap2    = tap2_q;
    assign bus.m_tap3    = tap3_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_last    = m_last_q;

    // sh0..sh2 hold the three most recent pixels (sh2 newest); p[0] is
    // replicated into all three so window 0 gets its left-edge clamp for free.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        drain_d   = drain_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        tap0_d    = tap0_q;
        tap1_d    = tap1_q;
        tap2_d    = tap2_q;
        tap3_d    = tap3_q;
        m_valid_d = m_valid_q && !bus.m_ready;
        m_last_d  = m_last_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (count_q == 2'd0) begin
                        sh0_d = bus.s_pixel;
                        sh1_d = bus.s_pixel;
                        sh2_d = bus.s_pixel;
                    end else begin
                        sh0_d = sh1_q;
                        sh1_d = sh2_q;
                        sh2_d = bus.s_pixel;
                    end
                    if (count_q == 2'd2) begin
                        tap0_d    = widen(sh0_q);
                        tap1_d    = widen(sh1_q);
                        tap2_d    = widen(sh2_q);
                        tap3_d    = widen(bus.s_pixel);
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                    end
                    if (bus.s_last) begin
                        state_d = DRAIN;
                        count_d = '0;
                        drain_d = (count_q == 2'd0) ? 2'd1 : 2'd2;
                    end else if (count_q == 2'd2) begin
                        state_d = STREAM;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    tap0_d    = widen(sh0_q);
                    tap1_d    = widen(sh1_q);
                    tap2_d    = widen(sh2_q);
                    tap3_d    = widen(bus.s_pixel);
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    sh0_d     = sh1_q;
                    sh1_d     = sh2_q;
                    sh2_d     = bus.s_pixel;
                    if (bus.s_last) begin
                        state_d = DRAIN;
                        drain_d = 2'd2;
                    end
                end
            end
            DRAIN: begin
                // Right-edge clamp: keep shifting the final pixel back in.
                if (out_free) begin
                    tap0_d    = widen(sh0_q);
                    tap1_d    = widen(sh1_q);
                    tap2_d    = widen(sh2_q);
                    tap3_d    = widen(sh2_q);
                    m_valid_d = 1'b1;
                    m_last_d  = (drain_q == 2'd1);
                    sh0_d     = sh1_q;
                    sh1_d     = sh2_q;
                    drain_d   = drain_q - 2'd1;
                    if (drain_q == 2'd1) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= FILL;
            count_q   <= '0;
            drain_q   <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            tap0_q    <= '0;
            tap1_q    <= '0;
            tap2_q    <= '0;
            tap3_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            drain_q   <= drain_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            tap0_q    <= tap0_d;
            tap1_q    <= tap1_d;
            tap2_q    <= tap2_d;
            tap3_q    <= tap3_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: tb/tb_pixel_window_input.sv
// Bench for pixel_window_input: directed and random lines checked against a
// line-level window model built from clamp(x-1+k, 0, N-1).
module tb_pixel_window_input;
    localparam int OW = 9;

    typedef struct packed {
        logic [3:0][OW-1:0] t;
        logic               last;
    } win_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    pixel_window_input_if #(.OUTPUT_WIDTH(OW)) bus ();
    pixel_window_input #(.OUTPUT_WIDTH(OW)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         rmode = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0
    int         cyc = 0;
    logic [7:0] px[$];
    logic [7:0] cur_line[$];
    logic [7:0] done_pix[$];
    int         lens[$];
    win_t       got[$];
    logic       drain = 1'b0;
    logic       prev_stall = 1'b0;
    win_t       prev_w;

    task automatic clear_model();
        cur_line.delete();
        done_pix.delete();
        lens.delete();
        got.delete();
        drain = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic check_line();
        int n;
        int idx;
        logic [7:0] p[$];
        win_t e;
        n = (lens.size() > 0) ? lens.pop_front() : -1;
        for (int i = 0; i < n; i++) p.push_back(done_pix.pop_front());
        tests++;
        assert (got.size() === n) else begin
            fails++;
            $error("FAIL line_count: got %0d windows, expected %0d", got.size(), n);
        end
        for (int x = 0; x < n && x < got.size(); x++) begin
            for (int k = 0; k < 4; k++) begin
                idx = x - 1 + k;
                if (idx < 0) idx = 0;
                if (idx > n - 1) idx = n - 1;
                e.t[k] = OW'(p[idx]);
            end
            e.last = (x == n - 1);
            tests++;
            assert (got[x] === e) else begin
                fails++;
                $error("FAIL window[%0d] of N=%0d: got taps %0d,%0d,%0d,%0d last %0b, expected %0d,%0d,%0d,%0d last %0b",
                       x, n, got[x].t[0], got[x].t[1], got[x].t[2], got[x].t[3], got[x].last,
                       e.t[0], e.t[1], e.t[2], e.t[3], e.last);
            end
        end
        got.delete();
    endtask

    // Called at a negedge with inputs already set; samples 1 time unit later.
    task automatic step(output logic acc);
        logic emit;
        logic exp_rdy;
        win_t w;
        cyc++;
        case (rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = cyc[0];
            2:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = 1'b0;
        endcase
        #1;
        w.t    = {bus.m_tap3, bus.m_tap2, bus.m_tap1, bus.m_tap0};
        w.last = bus.m_last;
        if (prev_stall) begin
            tests++;
            assert (bus.m_valid === 1'b1 && w === prev_w) else begin
                fails++;
                $error("FAIL stall_hold: valid %0b taps %0d,%0d,%0d,%0d, expected held window %0d,%0d,%0d,%0d",
                       bus.m_valid, w.t[0], w.t[1], w.t[2], w.t[3],
                       prev_w.t[0], prev_w.t[1], prev_w.t[2], prev_w.t[3]);
            end
        end
        if (bus.m_valid && bus.m_last) drain = 1'b0;
        exp_rdy = !drain && (!bus.m_valid || bus.m_ready);
        tests++;
        assert (bus.s_ready === exp_rdy) else begin
            fails++;
            $error("FAIL s_ready: got %0b, expected %0b (cycle %0d)", bus.s_ready, exp_rdy, cyc);
        end
        acc  = bus.s_valid && bus.s_ready;
        emit = bus.m_valid && bus.m_ready;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_w = w;
        if (acc) begin
            cur_line.push_back(bus.s_pixel);
            if (bus.s_last) begin
                lens.push_back(cur_line.size());
                foreach (cur_line[i]) done_pix.push_back(cur_line[i]);
                cur_line.delete();
                drain = 1'b1;
            end
        end
        if (emit) begin
            got.push_back(w);
            if (w.last) check_line();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_line(input int cnt, input bit gaps);
        logic acc;
        int i;
        int budget;
        i = 0;
        budget = 0;
        while (i < cnt && budget < 300) begin
            bus.s_pixel = px[i];
            bus.s_last  = (i == px.size() - 1);
            bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(acc);
            if (acc) i++;
            budget++;
        end
        tests++;
        assert (i === cnt) else begin
            fails++;
            $error("FAIL send_line: accepted %0d pixels, expected %0d", i, cnt);
        end
    endtask

    task automatic flush();
        logic acc;
        bit   done;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (rmode == 3) rmode = 0;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step(acc);
            done = !drain && !bus.m_valid && (got.size() == 0) && (lens.size() == 0);
        end
        tests++;
        assert (done === 1'b1) else begin
            fails++;
            $error("FAIL flush: output not drained, pending windows %0d, expected 0", got.size());
        end
    endtask

    task automatic reset_after(input int k);
        logic [OW*4-1:0] taps;
        px.delete();
        for (int i = 0; i < 5; i++) px.push_back(8'(90 + i));
        rmode = (k >= 3) ? 3 : 0;
        send_line(k, 1'b0);
        if (k >= 3) begin
            tests++;
            assert (bus.m_valid === 1'b1) else begin
                fails++;
                $error("FAIL pre_reset_valid: got %0b, expected 1", bus.m_valid);
            end
        end
        #2 aresetn = 1'b0;
        #1;
        taps = {bus.m_tap3, bus.m_tap2, bus.m_tap1, bus.m_tap0};
        tests++;
        assert (bus.m_valid === 1'b0 && bus.m_last === 1'b0 && taps === '0) else begin
            fails++;
            $error("FAIL async_reset: valid %0b last %0b taps %0h, expected 0 0 0",
                   bus.m_valid, bus.m_last, taps);
        end
        bus.s_valid = 1'b0;
        clear_model();
        @(negedge clk);
        aresetn = 1'b1;
        rmode = 0;
    endtask

    initial begin
        logic [OW*4-1:0] taps;
        bus.s_pixel = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        taps = {bus.m_tap3, bus.m_tap2, bus.m_tap1, bus.m_tap0};
        tests++;
        assert (bus.m_valid === 1'b0 && bus.m_last === 1'b0 && taps === '0) else begin
            fails++;
            $error("FAIL reset_state: valid %0b last %0b taps %0h, expected 0 0 0",
                   bus.m_valid, bus.m_last, taps);
        end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1;
        tests++;
        assert (bus.s_ready === 1'b1) else begin
            fails++;
            $error("FAIL reset_ready: got %0b, expected 1", bus.s_ready);
        end
        @(negedge clk);

        rmode = 0;
        px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        send_line(6, 1'b0);
        flush();

        px = '{8'd200};
        send_line(1, 1'b0);
        flush();

        px = '{8'd5, 8'd255};
        send_line(2, 1'b0);
        flush();

        rmode = 1;
        px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        send_line(6, 1'b0);
        flush();

        rmode = 0;
        px = '{8'd11, 8'd12, 8'd13, 8'd14};
        send_line(4, 1'b0);
        px = '{8'd21, 8'd22, 8'd23};
        send_line(3, 1'b0);
        flush();

        for (int k = 2; k <= 3; k++) begin
            reset_after(k);
            px = '{8'd1, 8'd2, 8'd3, 8'd4};
            send_line(4, 1'b0);
            flush();
        end

        rmode = 2;
        for (int l = 0; l < 40; l++) begin
            int n;
            n = $urandom_range(1, 12);
            px.delete();
            for (int i = 0; i < n; i++) px.push_back(8'($urandom_range(0, 255)));
            send_line(n, 1'b1);
            if ($urandom_range(0, 3) == 0) flush();
        end
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
